// File: rtl/apb_cmd_arbiter_if.sv
// Bundle between the APB command arbiter and its environment: requester command/response
// channels, the command outputs into apb_master, and the observed APB bus.
interface apb_cmd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic                          transfer;
  logic                          read;
  logic                          write;
  logic [ADDR_WIDTH-1:0]         apb_paddr;
  logic [DATA_WIDTH-1:0]         apb_write_data;

  logic                          psel;
  logic                          penable;
  logic                          pready;
  logic                          pslverr;
  logic [DATA_WIDTH-1:0]         prdata;

  logic                          stall_flag;

  // master: the arbiter itself
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  psel, penable, pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output transfer, read, write, apb_paddr, apb_write_data,
    output stall_flag
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output psel, penable, pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  transfer, read, write, apb_paddr, apb_write_data,
    input  stall_flag
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Round-robin command arbiter in front of apb_master: one command in flight, completion
// observed on the APB bus, response routed back to the granted requester, stall watchdog.
//
//  state   | meaning
//  S_IDLE  | arbitrate; pulse req_ready to winner and latch its command
//  S_ISSUE | one-cycle transfer pulse into apb_master
//  S_WAIT  | command held; wait for psel&penable&pready, count watchdog
//  S_RESP  | one-cycle rsp_valid to the granted requester
module apb_cmd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 256
) (
  input logic               pclock,
  input logic               presetn,
  apb_cmd_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         last, winner, cand;
  logic                  any_req, done;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr, cmd_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, cmd_wdata;
  logic                  cmd_write;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  assign done = bus.psel & bus.penable & bus.pready;

  // search starts one past the previous winner so the last grantee goes to the back
  always_comb begin
    any_req = 1'b0;
    winner  = last;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done) state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      last      <= IW'(NUM_REQ - 1);
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && any_req) begin
        last      <= winner;
        cmd_write <= sel_write;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_write ? sel_wdata : '0;
      end
      // wait_cnt equals the number of the current WAIT cycle, saturating at TIMEOUT
      if (state == S_ISSUE)
        wait_cnt <= CW'(1);
      else if (state == S_WAIT) begin
        if (wait_cnt != CW'(TIMEOUT)) wait_cnt <= wait_cnt + CW'(1);
      end else
        wait_cnt <= '0;
      if (state == S_WAIT && done) begin
        rdata_q <= cmd_write ? '0 : bus.prdata;
        err_q   <= bus.pslverr;
      end
    end
  end

  always_comb begin
    bus.req_ready      = '0;
    bus.rsp_valid      = '0;
    bus.transfer       = 1'b0;
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    bus.apb_paddr      = '0;
    bus.apb_write_data = '0;
    case (state)
      S_IDLE: if (any_req) bus.req_ready[winner] = 1'b1;
      S_ISSUE, S_WAIT: begin
        bus.transfer       = (state == S_ISSUE);
        bus.read           = ~cmd_write;
        bus.write          = cmd_write;
        bus.apb_paddr      = cmd_addr;
        bus.apb_write_data = cmd_wdata;
      end
      default: bus.rsp_valid[last] = 1'b1;
    endcase
  end

  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.stall_flag = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT));
endmodule
